// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I
// datapath. It decides when the IR, register file and PC are written, and it
// drives the instruction and data memory request handshakes.
//
// Ports:
//   clk, rst_n      - core clock, asynchronous active-low reset
//   ir_opcode_i     - opcode field of the instruction register
//   imem_ready_i    - instruction memory returns the fetch this cycle
//   dmem_ready_i    - data memory completes the access this cycle
//   imem_req_o      - instruction fetch request (FETCH)
//   dmem_req_o      - data memory request (MEM)
//   dmem_we_o       - data access is a store (only with dmem_req_o)
//   ir_we_o         - capture the fetched instruction (FETCH && imem_ready_i)
//   rf_we_o         - register file write strobe (WB of a writing instr)
//   pc_we_o         - PC update strobe (WB)
//   halted_o        - core stopped
//   illegal_o       - halt was caused by an unrecognised opcode
//   state_o         - current state encoding
//   cycle_cnt_o     - active-cycle counter
//   instret_cnt_o   - retired-instruction counter
//
// Build option: define SEQ_PERF_CNT_EN to implement the two performance
// counters; without it both counter outputs are tied to zero.

module core_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  ir_opcode_i,
    input  logic        imem_ready_i,
    input  logic        dmem_ready_i,
    output logic        imem_req_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic        ir_we_o,
    output logic        rf_we_o,
    output logic        pc_we_o,
    output logic        halted_o,
    output logic        illegal_o,
    output logic [2:0]  state_o,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instret_cnt_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    state_t state;

    // Classification captured in DECODE; the opcode itself is not
    // trusted after DECODE, so everything later runs off these flags.
    logic mem_flag;
    logic wb_flag;
    logic st_flag;

    // Registered outputs, always loaded with the value that matches
    // the state being entered, so they are a pure function of state.
    logic imem_req;
    logic dmem_req;
    logic dmem_we;
    logic rf_we;
    logic pc_we;
    logic halted;
    logic illegal;

    // Opcode classification (combinational, consumed only in DECODE).
    logic dec_exec;
    logic dec_mem;
    logic dec_st;
    logic dec_wb;
    logic dec_sys;

    always_comb begin
        dec_exec = 1'b1;
        dec_mem  = 1'b0;
        dec_st   = 1'b0;
        dec_wb   = 1'b0;
        dec_sys  = 1'b0;
        case (ir_opcode_i)
            7'b0000011: begin
                dec_mem = 1'b1;
                dec_wb  = 1'b1;
            end
            7'b0100011: begin
                dec_mem = 1'b1;
                dec_st  = 1'b1;
            end
            7'b0110011,
            7'b0010011,
            7'b0110111,
            7'b0010111,
            7'b1101111,
            7'b1100111: dec_wb = 1'b1;
            7'b1100011,
            7'b0001111: dec_wb = 1'b0;
            7'b1110011: begin
                dec_exec = 1'b0;
                dec_sys  = 1'b1;
            end
            default: dec_exec = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mem_flag <= 1'b0;
            wb_flag  <= 1'b0;
            st_flag  <= 1'b0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            rf_we    <= 1'b0;
            pc_we    <= 1'b0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ready_i) begin
                        state    <= DECODE;
                        imem_req <= 1'b0;
                    end
                end
                DECODE: begin
                    mem_flag <= dec_mem;
                    wb_flag  <= dec_wb;
                    st_flag  <= dec_st;
                    if (dec_exec) begin
                        state <= EXEC;
                    end else begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        illegal <= !dec_sys;
                    end
                end
                EXEC: begin
                    if (mem_flag) begin
                        state    <= MEM;
                        dmem_req <= 1'b1;
                        dmem_we  <= st_flag;
                    end else begin
                        state <= WB;
                        pc_we <= 1'b1;
                        rf_we <= wb_flag;
                    end
                end
                MEM: begin
                    if (dmem_ready_i) begin
                        state    <= WB;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        pc_we    <= 1'b1;
                        rf_we    <= wb_flag;
                    end
                end
                WB: begin
                    state    <= FETCH;
                    pc_we    <= 1'b0;
                    rf_we    <= 1'b0;
                    imem_req <= 1'b1;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    // Unused encoding: fall back to a clean IDLE.
                    state    <= IDLE;
                    imem_req <= 1'b0;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    rf_we    <= 1'b0;
                    pc_we    <= 1'b0;
                    halted   <= 1'b0;
                    illegal  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o = imem_req;
    assign dmem_req_o = dmem_req;
    assign dmem_we_o  = dmem_we;
    assign rf_we_o    = rf_we;
    assign pc_we_o    = pc_we;
    assign halted_o   = halted;
    assign illegal_o  = illegal;
    assign state_o    = state;

    // The IR write is the one strobe that follows the ready input
    // directly, so the instruction is captured on the accepting edge.
    assign ir_we_o = (state == FETCH) && imem_ready_i;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else begin
            if (state != IDLE && state != HALT) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (state == WB) begin
                instret_cnt <= instret_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt_o   = cycle_cnt;
    assign instret_cnt_o = instret_cnt;
`else
    assign cycle_cnt_o   = 32'd0;
    assign instret_cnt_o = 32'd0;
`endif

endmodule
